// File: rtl/pe_array_pkg.sv
// Shared PE-array definitions: ifmap GIN tag widths and the
// ifmap dispatcher state encoding.
package pe_array_pkg;

    localparam int IFMAP_ROW_TAG_W = 4;
    localparam int IFMAP_COL_TAG_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } disp_state_e;

endpackage

// File: rtl/ifmap_gin_dispatcher_tag_sweep_counter.sv
// Nested burst/column/row counters for the ifmap GIN dispatcher,
// with wrap handling and detection of the final word of a pass.
module tag_sweep_counter
    import pe_array_pkg::*;
#(
    parameter int ROW_TAG_WIDTH = IFMAP_ROW_TAG_W,
    parameter int COL_TAG_WIDTH = IFMAP_COL_TAG_W,
    parameter int BURST_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_i,
    input  logic                     step_i,
    input  logic [ROW_TAG_WIDTH-1:0] row_last_i,
    input  logic [COL_TAG_WIDTH-1:0] col_last_i,
    input  logic [BURST_WIDTH-1:0]   burst_last_i,
    output logic [COL_TAG_WIDTH-1:0] c_o,
    output logic [ROW_TAG_WIDTH-1:0] r_o,
    output logic                     final_o
);

    logic [BURST_WIDTH-1:0]   b_q, b_d;
    logic [COL_TAG_WIDTH-1:0] c_q, c_d;
    logic [ROW_TAG_WIDTH-1:0] r_q, r_d;

    assign final_o = (b_q == burst_last_i) && (c_q == col_last_i)
                  && (r_q == row_last_i);
    assign c_o = c_q;
    assign r_o = r_q;

    always_comb begin
        b_d = b_q;
        c_d = c_q;
        r_d = r_q;
        if (clear_i) begin
            b_d = '0;
            c_d = '0;
            r_d = '0;
        end else if (step_i) begin
            if (b_q == burst_last_i) begin
                b_d = '0;
                if (c_q == col_last_i) begin
                    c_d = '0;
                    r_d = r_q + 1'b1;
                end else begin
                    c_d = c_q + 1'b1;
                end
            end else begin
                b_d = b_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b_q <= '0;
            c_q <= '0;
            r_q <= '0;
        end else begin
            b_q <= b_d;
            c_q <= c_d;
            r_q <= r_d;
        end
    end

endmodule

// File: rtl/ifmap_gin_dispatcher.sv
// Feeds global-buffer ifmap words into the GIN data/tag FIFOs in lockstep.
// Define IFMAP_DISPATCH_PERF_CNT_EN to add the stall_cycles counter port.
module ifmap_gin_dispatcher
    import pe_array_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ROW_TAG_WIDTH = IFMAP_ROW_TAG_W,
    parameter int COL_TAG_WIDTH = IFMAP_COL_TAG_W,
    parameter int BURST_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ROW_TAG_WIDTH-1:0] row_last,
    input  logic [COL_TAG_WIDTH-1:0] col_last,
    input  logic [BURST_WIDTH-1:0]   burst_last,
    input  logic [ROW_TAG_WIDTH-1:0] row_base,
    output logic                     busy,
    output logic                     done,
    input  logic [DATA_WIDTH-1:0]    glb_data,
    input  logic                     glb_valid,
    output logic                     glb_ready,
    output logic [DATA_WIDTH-1:0]    ifmap_to_gin,
    output logic                     push_ifmap_to_gin,
    input  logic                     ifmap_gin_fifo_full,
    output logic [ROW_TAG_WIDTH-1:0] ifmap_row_tag,
    output logic [COL_TAG_WIDTH-1:0] ifmap_col_tag,
    output logic                     ifmap_tags_wr_en,
    input  logic                     ifmap_tags_full
`ifdef IFMAP_DISPATCH_PERF_CNT_EN
    ,
    output logic [31:0]              stall_cycles
`endif
);

    disp_state_e              state_q;
    logic                     busy_q, done_q;
    logic [ROW_TAG_WIDTH-1:0] row_last_q, row_base_q;
    logic [COL_TAG_WIDTH-1:0] col_last_q;
    logic [BURST_WIDTH-1:0]   burst_last_q;
    logic [COL_TAG_WIDTH-1:0] c;
    logic [ROW_TAG_WIDTH-1:0] r;
    logic                     accept, push, final_word;

    assign accept = (state_q == IDLE) && start;
    // One enable for both FIFOs keeps data and tags from drifting apart.
    assign push = (state_q == RUN) && glb_valid
               && !ifmap_gin_fifo_full && !ifmap_tags_full;

    assign glb_ready         = push;
    assign push_ifmap_to_gin = push;
    assign ifmap_tags_wr_en  = push;
    assign ifmap_to_gin      = glb_data;
    assign ifmap_row_tag     = row_base_q + r;
    assign ifmap_col_tag     = c;
    assign busy              = busy_q;
    assign done              = done_q;

    tag_sweep_counter #(
        .ROW_TAG_WIDTH(ROW_TAG_WIDTH),
        .COL_TAG_WIDTH(COL_TAG_WIDTH),
        .BURST_WIDTH  (BURST_WIDTH)
    ) u_sweep (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (accept),
        .step_i      (push),
        .row_last_i  (row_last_q),
        .col_last_i  (col_last_q),
        .burst_last_i(burst_last_q),
        .c_o         (c),
        .r_o         (r),
        .final_o     (final_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            row_last_q   <= '0;
            col_last_q   <= '0;
            burst_last_q <= '0;
            row_base_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q      <= RUN;
                        busy_q       <= 1'b1;
                        row_last_q   <= row_last;
                        col_last_q   <= col_last;
                        burst_last_q <= burst_last;
                        row_base_q   <= row_base;
                    end
                end
                RUN: begin
                    if (push && final_word) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFMAP_DISPATCH_PERF_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (accept) begin
            stall_q <= '0;
        end else if ((state_q == RUN) && glb_valid && !push
                     && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_ifmap_gin_dispatcher.sv
// Scoreboard bench for ifmap_gin_dispatcher: expected (row,col,data)
// entries are queued per pass and popped on every observed push.
module tb_ifmap_gin_dispatcher;

    localparam int DW = 16;
    localparam int RW = 4;
    localparam int CW = 5;
    localparam int BW = 8;
    localparam logic [DW-1:0] DB = 16'hA000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [RW-1:0] row_last = '0;
    logic [CW-1:0] col_last = '0;
    logic [BW-1:0] burst_last = '0;
    logic [RW-1:0] row_base = '0;
    logic          busy, done;
    logic [DW-1:0] glb_data = DB;
    logic          glb_valid = 1'b1;
    logic          glb_ready;
    logic [DW-1:0] ifmap_to_gin;
    logic          push_ifmap_to_gin;
    logic          ifmap_gin_fifo_full = 1'b0;
    logic [RW-1:0] ifmap_row_tag;
    logic [CW-1:0] ifmap_col_tag;
    logic          ifmap_tags_wr_en;
    logic          ifmap_tags_full = 1'b0;
`ifdef IFMAP_DISPATCH_PERF_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    typedef struct packed {
        logic [RW-1:0] row;
        logic [CW-1:0] col;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    int n_push = 0;
    int n_tag = 0;
    int cyc_n = 0;
    int last_push_cyc = -10;

    ifmap_gin_dispatcher dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .row_last           (row_last),
        .col_last           (col_last),
        .burst_last         (burst_last),
        .row_base           (row_base),
        .busy               (busy),
        .done               (done),
        .glb_data           (glb_data),
        .glb_valid          (glb_valid),
        .glb_ready          (glb_ready),
        .ifmap_to_gin       (ifmap_to_gin),
        .push_ifmap_to_gin  (push_ifmap_to_gin),
        .ifmap_gin_fifo_full(ifmap_gin_fifo_full),
        .ifmap_row_tag      (ifmap_row_tag),
        .ifmap_col_tag      (ifmap_col_tag),
        .ifmap_tags_wr_en   (ifmap_tags_wr_en),
        .ifmap_tags_full    (ifmap_tags_full)
`ifdef IFMAP_DISPATCH_PERF_CNT_EN
        ,
        .stall_cycles       (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard monitor; the source word advances once it is consumed.
    always @(negedge clk) begin
        exp_t e;
        cyc_n++;
        checks++;
        if (ifmap_tags_wr_en !== push_ifmap_to_gin ||
            glb_ready !== push_ifmap_to_gin) begin
            errors++;
            $display("FAIL coincide cyc=%0d push=%b tag_wr=%b rdy=%b",
                     cyc_n, push_ifmap_to_gin, ifmap_tags_wr_en, glb_ready);
        end
        if (ifmap_tags_wr_en === 1'b1) n_tag++;
        if (push_ifmap_to_gin === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_push got tag=(%0d,%0d) data=%h, want none",
                         ifmap_row_tag, ifmap_col_tag, ifmap_to_gin);
            end else begin
                e = sb.pop_front();
                if (ifmap_row_tag !== e.row || ifmap_col_tag !== e.col ||
                    ifmap_to_gin !== e.data) begin
                    errors++;
                    $display("FAIL push_word got (%0d,%0d,%h) want (%0d,%0d,%h)",
                             ifmap_row_tag, ifmap_col_tag, ifmap_to_gin,
                             e.row, e.col, e.data);
                end
            end
            n_push++;
            last_push_cyc = cyc_n;
            glb_data = DB + DW'(n_push);
        end
    end

    task automatic sb_load(input int rl, input int cl, input int bl,
                           input int base);
        int idx;
        exp_t e;
        idx = 0;
        for (int r = 0; r <= rl; r++)
            for (int c = 0; c <= cl; c++)
                for (int b = 0; b <= bl; b++) begin
                    e.row  = RW'(base + r);
                    e.col  = CW'(c);
                    e.data = DB + DW'(n_push + idx);
                    sb.push_back(e);
                    idx++;
                end
    endtask

    task automatic set_cfg(input int rl, input int cl, input int bl,
                           input int base);
        row_last   = RW'(rl);
        col_last   = CW'(cl);
        burst_last = BW'(bl);
        row_base   = RW'(base);
        sb_load(rl, cl, bl, base);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(output int dc, input int limit);
        dc = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk); #1;
            if (done === 1'b1) begin
                dc = cyc_n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || push_ifmap_to_gin !== 1'b0 ||
            glb_ready !== 1'b0 || ifmap_tags_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got busy=%b done=%b push=%b rdy=%b wr=%b want 0",
                     busy, done, push_ifmap_to_gin, glb_ready, ifmap_tags_wr_en);
        end
        checks++;
        if (ifmap_row_tag !== '0 || ifmap_col_tag !== '0) begin
            errors++;
            $display("FAIL reset_tags got (%0d,%0d) want (0,0)",
                     ifmap_row_tag, ifmap_col_tag);
        end
`ifdef IFMAP_DISPATCH_PERF_CNT_EN
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_stall got %0d want 0", stall_cycles);
        end
`endif
        @(posedge clk); #1 reset = 1'b1;
    endtask

    task automatic test_basic_sweep();
        int p0, dc;
        set_cfg(1, 2, 0, 3);
        p0 = n_push;
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy got %b want 1", busy);
        end
        wait_done(dc, 50);
        checks++;
        if (dc < 0) begin
            errors++;
            $display("FAIL basic_done_timeout got none want done");
        end
        checks++;
        if (n_push - p0 != 6) begin
            errors++;
            $display("FAIL basic_count got %0d want 6", n_push - p0);
        end
        checks++;
        if (dc != last_push_cyc + 1) begin
            errors++;
            $display("FAIL basic_done_cycle got %0d want %0d", dc, last_push_cyc + 1);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_at_done got %b want 0", busy);
        end
        @(negedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_width got %b want 0", done);
        end
    endtask

    task automatic test_burst_valid_gaps();
        int p0, dc;
        set_cfg(0, 0, 3, 9);
        p0 = n_push;
        pulse_start();
        dc = -1;
        for (int i = 0; i < 80 && dc < 0; i++) begin
            glb_valid = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
            if (done === 1'b1) dc = cyc_n;
            @(posedge clk); #1;
        end
        glb_valid = 1'b1;
        checks++;
        if (dc < 0 || n_push - p0 != 4) begin
            errors++;
            $display("FAIL burst_count got %0d (done_cyc %0d) want 4", n_push - p0, dc);
        end
    endtask

    task automatic test_tag_stall();
        int p0, dc;
        logic [RW-1:0] hr;
        logic [CW-1:0] hc;
        bit bad;
        set_cfg(1, 2, 1, 2);
        p0 = n_push;
        pulse_start();
        for (int i = 0; i < 20 && n_push - p0 < 4; i++) begin
            @(posedge clk); #1;
        end
        ifmap_tags_full = 1'b1;
        hr = ifmap_row_tag;
        hc = ifmap_col_tag;
        checks++;
        if (hr !== 4'd2 || hc !== 5'd2) begin
            errors++;
            $display("FAIL stall_next_tag got (%0d,%0d) want (2,2)", hr, hc);
        end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (push_ifmap_to_gin !== 1'b0 || glb_ready !== 1'b0 ||
                ifmap_tags_wr_en !== 1'b0 || ifmap_row_tag !== hr ||
                ifmap_col_tag !== hc) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stall_hold got activity or tag change want frozen at (%0d,%0d)",
                     hr, hc);
        end
        @(posedge clk); #1 ifmap_tags_full = 1'b0;
        wait_done(dc, 50);
        checks++;
        if (dc < 0 || n_push - p0 != 12) begin
            errors++;
            $display("FAIL stall_count got %0d want 12", n_push - p0);
        end
`ifdef IFMAP_DISPATCH_PERF_CNT_EN
        checks++;
        if (stall_cycles !== 32'd5) begin
            errors++;
            $display("FAIL stall_cycles got %0d want 5", stall_cycles);
        end
`endif
    endtask

    task automatic test_data_full_toggle();
        int p0, t0, dc;
        set_cfg(0, 2, 1, 7);
        p0 = n_push;
        t0 = n_tag;
        pulse_start();
        dc = -1;
        for (int i = 0; i < 60 && dc < 0; i++) begin
            @(negedge clk); #1;
            if (done === 1'b1) dc = cyc_n;
            @(posedge clk); #1 ifmap_gin_fifo_full = ~ifmap_gin_fifo_full;
        end
        ifmap_gin_fifo_full = 1'b0;
        checks++;
        if (dc < 0 || n_push - p0 != 6 || n_tag - t0 != 6) begin
            errors++;
            $display("FAIL toggle_counts got data=%0d tags=%0d want 6/6",
                     n_push - p0, n_tag - t0);
        end
    endtask

    task automatic test_reset_abort();
        int p0, dc;
        bit saw;
        set_cfg(1, 2, 0, 5);
        p0 = n_push;
        pulse_start();
        for (int i = 0; i < 20 && n_push - p0 < 3; i++) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || push_ifmap_to_gin !== 1'b0 ||
            ifmap_tags_wr_en !== 1'b0 || glb_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got busy=%b push=%b wr=%b rdy=%b done=%b want 0",
                     busy, push_ifmap_to_gin, ifmap_tags_wr_en, glb_ready, done);
        end
        @(posedge clk); #1 reset = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done !== 1'b0) saw = 1'b1;
        end
        checks++;
        if (saw || n_push - p0 != 3) begin
            errors++;
            $display("FAIL abort_no_done got done_seen=%b pushes=%0d want 0/3",
                     saw, n_push - p0);
        end
        set_cfg(1, 2, 0, 5);
        p0 = n_push;
        pulse_start();
        checks++;
        if (ifmap_row_tag !== 4'd5 || ifmap_col_tag !== 5'd0) begin
            errors++;
            $display("FAIL replay_first_tag got (%0d,%0d) want (5,0)",
                     ifmap_row_tag, ifmap_col_tag);
        end
        wait_done(dc, 50);
        checks++;
        if (dc < 0 || n_push - p0 != 6) begin
            errors++;
            $display("FAIL replay_count got %0d want 6", n_push - p0);
        end
    endtask

    task automatic test_start_ignored();
        int p0, dc;
        bit bad;
        set_cfg(0, 1, 2, 1);
        p0 = n_push;
        pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(dc, 50);
        checks++;
        if (dc < 0 || n_push - p0 != 6) begin
            errors++;
            $display("FAIL restart_count got %0d want 6", n_push - p0);
        end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || push_ifmap_to_gin !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL restart_idle got busy/push after done want idle");
        end
    endtask

    initial begin
        #2 reset = 1'b0;
        test_reset();
        test_basic_sweep();
        test_burst_valid_gaps();
        test_tag_stall();
        test_data_full_toggle();
        test_reset_abort();
        test_start_ignored();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drained got %0d left want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
